// File: rtl/random_trace_generator.sv
// Random 4x4 spell-trace generator.
// Synchronizes and von Neumann-debiases an external random bit, packs 16
// emitted bits into a candidate and publishes it when its cell count is in
// range and it differs from the currently displayed trace.
module random_trace_generator #(
   parameter int unsigned MIN_CELLS = 4,
   parameter int unsigned MAX_CELLS = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RBG,
   output logic [15:0] trace,
   output logic        save_trace
);

   localparam logic [4:0] MIN_C = 5'(MIN_CELLS);
   localparam logic [4:0] MAX_C = 5'(MAX_CELLS);

   logic        rbg_m;
   logic        rbg_s;
   logic        pending;
   logic        first_bit;
   // Only 15 bits are held: the 16th bit goes straight into cand.
   logic [14:0] shift_reg;
   logic [4:0]  count;
   logic [15:0] cand;
   logic        cand_valid;

   logic        emit_valid;
   logic        emit_bit;
   logic [4:0]  pop;
   logic        accept;

   // Two-flop synchronizer for the asynchronous pin
   always_ff @(posedge clk) begin
      if (reset) begin
         rbg_m <= 1'b0;
         rbg_s <= 1'b0;
      end else begin
         rbg_m <= RBG;
         rbg_s <= rbg_m;
      end
   end

   // Debiaser pair decode: (1,0) -> 1, (0,1) -> 0, equal pairs -> nothing
   always_comb begin
      emit_valid = pending && (first_bit != rbg_s);
      emit_bit   = first_bit;
   end

   // Debiaser pair tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         pending   <= 1'b0;
         first_bit <= 1'b0;
      end else if (!pending) begin
         pending   <= 1'b1;
         first_bit <= rbg_s;
      end else begin
         pending   <= 1'b0;
      end
   end

   // Accumulate emitted bits MSB-first and hand off completed candidates
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg  <= '0;
         count      <= '0;
         cand       <= '0;
         cand_valid <= 1'b0;
      end else begin
         cand_valid <= 1'b0;
         if (emit_valid) begin
            if (count == 5'd15) begin
               cand       <= {shift_reg, emit_bit};
               cand_valid <= 1'b1;
               shift_reg  <= '0;
               count      <= '0;
            end else begin
               shift_reg <= {shift_reg[13:0], emit_bit};
               count     <= count + 5'd1;
            end
         end
      end
   end

   // Cell count of the pending candidate
   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         pop = pop + {4'b0000, cand[i]};
      end
   end

   // Acceptance: cell count in range and not a repeat of the shown trace
   always_comb begin
      accept = cand_valid && (pop >= MIN_C) && (pop <= MAX_C) &&
               !(save_trace && (cand == trace));
   end

   // Publish accepted candidates; save_trace stays set until reset
   always_ff @(posedge clk) begin
      if (reset) begin
         trace      <= '0;
         save_trace <= 1'b0;
      end else if (accept) begin
         trace      <= cand;
         save_trace <= 1'b1;
      end
   end

endmodule

// File: tb/tb_random_trace_generator.sv
// Directed bench for random_trace_generator: drives pair-encoded bit streams
// on RBG and checks reset state, exact update latency, discarded pairs,
// cell-count limits, duplicate suppression and mid-stream reset.
module tb_random_trace_generator;

   logic        clk;
   logic        reset;
   logic        RBG;
   logic [15:0] trace;
   logic        save_trace;

   int unsigned checks;
   int unsigned errors;
   logic [15:0] prev_trace;
   logic        prev_save;

   random_trace_generator #(
      .MIN_CELLS(4),
      .MAX_CELLS(10)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .RBG       (RBG),
      .trace     (trace),
      .save_trace(save_trace)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #1000000;
      $display("FAIL watchdog: observed no end, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One RBG sample per clock, set on the falling edge
   task automatic drive(input logic b);
      RBG = b;
      @(negedge clk);
   endtask

   // Reset for 3 cycles with RBG toggling; release on a falling edge so the
   // next sample starts on a pair boundary.
   task automatic apply_reset(input string tag);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         RBG = ~RBG;
         @(negedge clk);
      end
      check({tag, "_trace"}, trace, 16'h0000);
      check({tag, "_save"}, {15'd0, save_trace}, 16'h0001 & 16'h0000);
      reset      = 1'b0;
      prev_trace = 16'h0000;
      prev_save  = 1'b0;
   endtask

   // Feed one word MSB-first, optionally preceding each bit with a discarded
   // pair, then pad with (1,1) pairs while checking the exact update edge.
   task automatic feed(input string tag, input logic [15:0] w, input bit ilv,
                       input logic [15:0] exp_trace, input logic exp_save);
      for (int i = 15; i >= 0; i--) begin
         if (ilv) begin
            drive(i[0]);
            drive(i[0]);
         end
         drive(w[i]);
         drive(~w[i]);
      end
      drive(1'b1);
      drive(1'b1);
      check({tag, "_early_trace"}, trace, prev_trace);
      check({tag, "_early_save"}, {15'd0, save_trace}, {15'd0, prev_save});
      drive(1'b1);
      check({tag, "_trace"}, trace, exp_trace);
      check({tag, "_save"}, {15'd0, save_trace}, {15'd0, exp_save});
      drive(1'b1);
      prev_trace = exp_trace;
      prev_save  = exp_save;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      RBG    = 1'b0;
      prev_trace = 16'h0000;
      prev_save  = 1'b0;
      @(negedge clk);

      // Reset, then constant RBG never emits bits
      apply_reset("reset");
      for (int i = 0; i < 200; i++) drive(1'b1);
      check("const_trace", trace, 16'h0000);
      check("const_save", {15'd0, save_trace}, 16'h0000);

      // Plain valid trace with exact latency
      apply_reset("reset2");
      feed("valid", 16'h0231, 1'b0, 16'h0231, 1'b1);

      // Same pattern with an equal pair before every bit
      apply_reset("reset3");
      feed("discard", 16'h0231, 1'b1, 16'h0231, 1'b1);

      // Cell-count limits
      feed("pop2",  16'h0003, 1'b0, 16'h0231, 1'b1);
      feed("pop16", 16'hFFFF, 1'b0, 16'h0231, 1'b1);
      feed("pop4",  16'h000F, 1'b0, 16'h000F, 1'b1);
      feed("pop10", 16'h03FF, 1'b0, 16'h03FF, 1'b1);
      feed("pop11", 16'h07FF, 1'b0, 16'h03FF, 1'b1);

      // Consecutive duplicate suppression
      feed("dup_a", 16'h0231, 1'b0, 16'h0231, 1'b1);
      feed("dup_b", 16'h0231, 1'b0, 16'h0231, 1'b1);
      feed("dup_c", 16'h8CA9, 1'b0, 16'h8CA9, 1'b1);

      // Reset after 20 emitted bits, then a clean stream
      for (int i = 15; i >= 0; i--) begin
         drive(i[0]);
         drive(~i[0]);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1);
         drive(1'b0);
      end
      apply_reset("midreset");
      feed("after_reset", 16'h0F0F, 1'b0, 16'h0F0F, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
